// File: rtl/game_rom_bridge.sv
// game_rom_bridge: fabric-side responder for the SoC game-ROM conduit.
// Turns SoC strobe edges into single-byte RAM transactions and arbitrates
// the RAM port with NES cartridge reads under a starvation guard.
//
// Ports:
//   clk_clk, reset_reset_n       clock, synchronous active-low reset
//   rom_addr, to_game_rom        SoC address / write data
//   write_rom, read_rom          SoC level strobes (rising edge = one op)
//   from_game_rom                last SoC read data
//   nes_req, nes_addr            NES read request (held until nes_rvalid)
//   nes_rdata, nes_rvalid        NES read data and one-cycle valid
//   mem_addr, mem_wdata          RAM address / write data
//   mem_we, mem_re, mem_rdata    RAM strobes, read data one cycle after re
//   wr_count_clr, wr_count       SoC write byte counter and its clear
//   soc_busy, soc_overrun        SoC op pending/in flight, sticky overrun
module game_rom_bridge #(
   parameter int SYNC_STAGES = 2,
   parameter int STARVE_MAX  = 4
) (
   input  logic        clk_clk,
   input  logic        reset_reset_n,
   input  logic [15:0] rom_addr,
   input  logic [7:0]  to_game_rom,
   input  logic        write_rom,
   input  logic        read_rom,
   output logic [7:0]  from_game_rom,
   input  logic        nes_req,
   input  logic [15:0] nes_addr,
   output logic [7:0]  nes_rdata,
   output logic        nes_rvalid,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        mem_we,
   output logic        mem_re,
   input  logic [7:0]  mem_rdata,
   input  logic        wr_count_clr,
   output logic [16:0] wr_count,
   output logic        soc_busy,
   output logic        soc_overrun
);

   localparam int CW = $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [SYNC_STAGES-1:0] wr_sync, rd_sync;
   logic        wr_prev, rd_prev;
   logic        wr_edge, rd_edge;
   logic        wr_pend, rd_pend;
   logic [15:0] wr_addr, rd_addr;
   logic [7:0]  wr_data;
   logic [CW-1:0] starve_cnt;
   logic        op_nes, op_wr;
   logic        gnt_nes, gnt_wr, gnt_rd, gnt_any;
   logic        soc_any, force_soc;
   logic        wr_done, rd_done;

   assign wr_edge   = wr_sync[SYNC_STAGES-1] & ~wr_prev;
   assign rd_edge   = rd_sync[SYNC_STAGES-1] & ~rd_prev;
   assign soc_any   = wr_pend | rd_pend;
   assign force_soc = soc_any && (starve_cnt == CW'(STARVE_MAX));
   assign gnt_any   = gnt_nes | gnt_wr | gnt_rd;

   // Flags stay set until the op completes so soc_busy covers the flight.
   assign wr_done = (state_q == ISSUE) && op_wr;
   assign rd_done = (state_q == CAPTURE) && !op_nes;

   assign soc_busy = soc_any | ((state_q != IDLE) && !op_nes);

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_nes = 1'b0;
      gnt_wr  = 1'b0;
      gnt_rd  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (force_soc) begin
               gnt_wr = wr_pend;
               gnt_rd = ~wr_pend;
            end else if (nes_req) begin
               gnt_nes = 1'b1;
            end else if (wr_pend) begin
               gnt_wr = 1'b1;
            end else if (rd_pend) begin
               gnt_rd = 1'b1;
            end
            if (gnt_nes || gnt_wr || gnt_rd) begin
               state_d = ISSUE;
            end
         end
         ISSUE:   state_d = op_wr ? IDLE : CAPTURE;
         CAPTURE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         wr_sync       <= '0;
         rd_sync       <= '0;
         wr_prev       <= 1'b0;
         rd_prev       <= 1'b0;
         wr_pend       <= 1'b0;
         rd_pend       <= 1'b0;
         wr_addr       <= '0;
         rd_addr       <= '0;
         wr_data       <= '0;
         starve_cnt    <= '0;
         op_nes        <= 1'b0;
         op_wr         <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         mem_we        <= 1'b0;
         mem_re        <= 1'b0;
         nes_rdata     <= '0;
         nes_rvalid    <= 1'b0;
         from_game_rom <= '0;
         wr_count      <= '0;
         soc_overrun   <= 1'b0;
      end else begin
         wr_sync <= {wr_sync[SYNC_STAGES-2:0], write_rom};
         rd_sync <= {rd_sync[SYNC_STAGES-2:0], read_rom};
         wr_prev <= wr_sync[SYNC_STAGES-1];
         rd_prev <= rd_sync[SYNC_STAGES-1];

         // Strobes are asserted for the single ISSUE cycle only.
         mem_we     <= 1'b0;
         mem_re     <= 1'b0;
         nes_rvalid <= 1'b0;

         if (gnt_any) begin
            op_nes <= gnt_nes;
            op_wr  <= gnt_wr;
            mem_we <= gnt_wr;
            mem_re <= ~gnt_wr;
            if (gnt_nes) begin
               mem_addr <= nes_addr;
            end else if (gnt_wr) begin
               mem_addr <= wr_addr;
            end else begin
               mem_addr <= rd_addr;
            end
            if (gnt_wr) begin
               mem_wdata <= wr_data;
            end
         end

         if (gnt_wr || gnt_rd) begin
            starve_cnt <= '0;
         end else if (gnt_nes && soc_any) begin
            if (starve_cnt != CW'(STARVE_MAX)) begin
               starve_cnt <= starve_cnt + CW'(1);
            end
         end else if (!soc_any) begin
            starve_cnt <= '0;
         end

         if (state_q == CAPTURE) begin
            if (op_nes) begin
               nes_rdata  <= mem_rdata;
               nes_rvalid <= 1'b1;
            end else begin
               from_game_rom <= mem_rdata;
            end
         end

         if (wr_count_clr) begin
            wr_count <= '0;
         end else if (wr_done) begin
            wr_count <= wr_count + 17'd1;
         end

         // A new edge wins over completion so it is never dropped.
         if (wr_edge) begin
            wr_pend <= 1'b1;
            wr_addr <= rom_addr;
            wr_data <= to_game_rom;
            if (wr_pend) begin
               soc_overrun <= 1'b1;
            end
         end else if (wr_done) begin
            wr_pend <= 1'b0;
         end

         if (rd_edge) begin
            rd_pend <= 1'b1;
            rd_addr <= rom_addr;
            if (rd_pend) begin
               soc_overrun <= 1'b1;
            end
         end else if (rd_done) begin
            rd_pend <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_game_rom_bridge.sv
// tb_game_rom_bridge: directed and randomized checks of game_rom_bridge
// against a byte-array memory model and transaction-level expectations.
module tb_game_rom_bridge;

   logic        clk_clk = 1'b0;
   logic        reset_reset_n = 1'b0;
   logic [15:0] rom_addr = '0;
   logic [7:0]  to_game_rom = '0;
   logic        write_rom = 1'b0;
   logic        read_rom = 1'b0;
   logic [7:0]  from_game_rom;
   logic        nes_req = 1'b0;
   logic [15:0] nes_addr = '0;
   logic [7:0]  nes_rdata;
   logic        nes_rvalid;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic        mem_re;
   logic [7:0]  mem_rdata = '0;
   logic        wr_count_clr = 1'b0;
   logic [16:0] wr_count;
   logic        soc_busy;
   logic        soc_overrun;

   game_rom_bridge #(.SYNC_STAGES(2), .STARVE_MAX(4)) dut (
      .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
      .rom_addr(rom_addr), .to_game_rom(to_game_rom),
      .write_rom(write_rom), .read_rom(read_rom),
      .from_game_rom(from_game_rom),
      .nes_req(nes_req), .nes_addr(nes_addr),
      .nes_rdata(nes_rdata), .nes_rvalid(nes_rvalid),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
      .wr_count_clr(wr_count_clr), .wr_count(wr_count),
      .soc_busy(soc_busy), .soc_overrun(soc_overrun)
   );

   always #5 clk_clk = ~clk_clk;

   // Environment RAM plus a backdoor port for preloading.
   logic [7:0]  ram [0:65535] = '{default: 8'h00};
   logic [7:0]  model [0:65535] = '{default: 8'h00};
   logic        bd_we = 1'b0;
   logic [15:0] bd_addr = '0;
   logic [7:0]  bd_data = '0;

   always @(posedge clk_clk) begin
      if (bd_we) ram[bd_addr] <= bd_data;
      if (mem_we) ram[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= ram[mem_addr];
   end

   int  n_tests = 0;
   int  n_fail = 0;
   int  wr_exp = 0;
   bit  rand_done = 1'b0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(negedge clk_clk);
   endtask

   task automatic bd_write(input logic [15:0] a, input logic [7:0] d);
      bd_addr = a;
      bd_data = d;
      bd_we = 1'b1;
      step();
      bd_we = 1'b0;
      model[a] = d;
   endtask

   task automatic check_zero(input string p);
      check({p, "_from"}, from_game_rom, 0);
      check({p, "_nrd"}, nes_rdata, 0);
      check({p, "_nrv"}, nes_rvalid, 0);
      check({p, "_maddr"}, mem_addr, 0);
      check({p, "_mwd"}, mem_wdata, 0);
      check({p, "_we_re"}, {mem_we, mem_re}, 0);
      check({p, "_wrcnt"}, wr_count, 0);
      check({p, "_busy"}, soc_busy, 0);
      check({p, "_ovr"}, soc_overrun, 0);
   endtask

   task automatic soc_op(input bit is_wr, input logic [15:0] a,
                         input logic [7:0] d);
      int k;
      rom_addr = a;
      to_game_rom = d;
      if (is_wr) write_rom = 1'b1;
      else read_rom = 1'b1;
      step(3);
      write_rom = 1'b0;
      read_rom = 1'b0;
      k = 0;
      while (soc_busy && k < 200) begin
         step();
         k++;
      end
      check("soc_timeout", k < 200, 1);
      step(2);
      if (is_wr) begin
         model[a] = d;
         wr_exp++;
         check("soc_wrcnt", wr_count, wr_exp);
      end else begin
         check("soc_rdata", from_game_rom, model[a]);
      end
   endtask

   task automatic nes_read(input logic [15:0] a, input bit chk_lat);
      int k;
      nes_addr = a;
      nes_req = 1'b1;
      k = 0;
      do begin
         step();
         k++;
      end while (!nes_rvalid && k < 100);
      check("nes_timeout", nes_rvalid, 1);
      check("nes_rdata", nes_rdata, model[a]);
      if (chk_lat) check("nes_latency", k, 3);
      nes_req = 1'b0;
   endtask

   initial begin
      int cnt;
      int nes_again;
      bit seen_busy;
      bit we_seen;
      logic [15:0] we_addr;

      step(3);
      check_zero("rst");
      reset_reset_n = 1'b1;
      for (int i = 0; i < 256; i++) bd_write(16'(i), 8'($urandom));
      bd_write(16'h1234, 8'($urandom));
      step(2);

      // Single write: strobe in cycle 4, count and busy drop in cycle 5.
      rom_addr = 16'h8000;
      to_game_rom = 8'hA5;
      write_rom = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         step();
         check($sformatf("w1_we_c%0d", c), mem_we, c == 4);
         check($sformatf("w1_re_c%0d", c), mem_re, 0);
         check($sformatf("w1_busy_c%0d", c), soc_busy, c == 3 || c == 4);
         check($sformatf("w1_cnt_c%0d", c), wr_count, c >= 5);
         if (c == 4) begin
            check("w1_addr", mem_addr, 16'h8000);
            check("w1_wdata", mem_wdata, 8'hA5);
         end
         if (c == 3) write_rom = 1'b0;
      end
      model[16'h8000] = 8'hA5;
      wr_exp = 1;

      // SoC read back.
      read_rom = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         step();
         check($sformatf("r1_re_c%0d", c), mem_re, c == 4);
         check($sformatf("r1_data_c%0d", c), from_game_rom,
               c >= 6 ? 32'(model[16'h8000]) : 32'h0);
         if (c == 4) check("r1_addr", mem_addr, 16'h8000);
         if (c == 3) read_rom = 1'b0;
      end
      step(5);
      check("r1_hold", from_game_rom, 8'hA5);

      // NES read timing.
      nes_addr = 16'h1234;
      nes_req = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         step();
         check($sformatf("n1_re_c%0d", c), mem_re, c == 1);
         check($sformatf("n1_rv_c%0d", c), nes_rvalid, c == 3);
         if (c == 1) check("n1_addr", mem_addr, 16'h1234);
         if (c == 3) begin
            check("n1_data", nes_rdata, model[16'h1234]);
            nes_req = 1'b0;
         end
      end
      step(3);

      // Clear beats a simultaneous increment.
      rom_addr = 16'h8001;
      to_game_rom = 8'h77;
      write_rom = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         step();
         if (c == 3) write_rom = 1'b0;
         if (c == 4) begin
            check("clr_pre", wr_count, 1);
            check("clr_we", mem_we, 1);
            wr_count_clr = 1'b1;
         end
         if (c == 5) begin
            check("clr_prio", wr_count, 0);
            wr_count_clr = 1'b0;
         end
         if (c == 6) check("clr_hold", wr_count, 0);
      end
      model[16'h8001] = 8'h77;
      wr_exp = 0;
      step(3);

      // Simultaneous edges: write goes first, read sees new data.
      bd_write(16'h0010, 8'h00);
      step(2);
      rom_addr = 16'h0010;
      to_game_rom = 8'h3C;
      write_rom = 1'b1;
      read_rom = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         step();
         check($sformatf("sim_we_c%0d", c), mem_we, c == 4);
         check($sformatf("sim_re_c%0d", c), mem_re, c == 6);
         if (c == 6) check("sim_raddr", mem_addr, 16'h0010);
         if (c == 3) begin
            write_rom = 1'b0;
            read_rom = 1'b0;
         end
      end
      model[16'h0010] = 8'h3C;
      wr_exp++;
      check("sim_from", from_game_rom, 8'h3C);
      check("sim_ovr", soc_overrun, 0);
      check("sim_cnt", wr_count, wr_exp);

      // Starvation guard: exactly four NES grants before the SoC write.
      nes_addr = 16'h0100;
      nes_req = 1'b1;
      step();
      rom_addr = 16'h8002;
      to_game_rom = 8'h99;
      write_rom = 1'b1;
      cnt = 0;
      seen_busy = 1'b0;
      we_seen = 1'b0;
      we_addr = '0;
      for (int c = 1; c <= 200 && !we_seen; c++) begin
         step();
         if (c == 3) write_rom = 1'b0;
         if (mem_we) begin
            we_seen = 1'b1;
            we_addr = mem_addr;
         end else if (!seen_busy && soc_busy) begin
            seen_busy = 1'b1;
         end else if (seen_busy && mem_re) begin
            cnt++;
         end
         if (nes_rvalid) check("stv_nes_data", nes_rdata, model[16'h0100]);
      end
      check("stv_we_seen", we_seen, 1);
      check("stv_grants", cnt, 4);
      check("stv_we_addr", we_addr, 16'h8002);
      nes_again = 0;
      for (int c = 0; c < 10; c++) begin
         step();
         if (mem_re && mem_addr == 16'h0100) nes_again++;
      end
      check("stv_nes_again", nes_again > 0, 1);
      nes_req = 1'b0;
      model[16'h8002] = 8'h99;
      wr_exp++;
      step(8);
      check("stv_cnt", wr_count, wr_exp);

      // Randomized mix: SoC ops on 0x8000.., NES reads on 0x0000..0x00FF.
      fork
         begin
            while (!rand_done) begin
               step();
               check("we_re_excl", mem_we & mem_re, 0);
            end
         end
      join_none
      fork
         begin
            for (int i = 0; i < 30; i++) begin
               soc_op(1'($urandom_range(0, 1)),
                      16'h8000 + 16'($urandom_range(0, 15)),
                      8'($urandom));
               step($urandom_range(0, 4));
            end
         end
         begin
            for (int i = 0; i < 60; i++) begin
               nes_read(16'($urandom_range(0, 255)), 1'b0);
               step($urandom_range(0, 3));
            end
         end
      join
      rand_done = 1'b1;
      step(6);

      // Overrun: second write edge while the first is still pending.
      nes_addr = 16'h0100;
      nes_req = 1'b1;
      step();
      rom_addr = 16'h8003;
      to_game_rom = 8'h11;
      write_rom = 1'b1;
      step(2);
      write_rom = 1'b0;
      step(2);
      to_game_rom = 8'h22;
      write_rom = 1'b1;
      step(2);
      write_rom = 1'b0;
      cnt = 0;
      while (soc_busy && cnt < 200) begin
         step();
         cnt++;
      end
      check("ovr_timeout", cnt < 200, 1);
      nes_req = 1'b0;
      step(8);
      model[16'h8003] = 8'h22;
      wr_exp++;
      check("ovr_flag", soc_overrun, 1);
      check("ovr_cnt", wr_count, wr_exp);
      soc_op(1'b0, 16'h8003, 8'h00);
      check("ovr_sticky", soc_overrun, 1);

      // Reset during CAPTURE abandons the read.
      nes_addr = 16'h0042;
      nes_req = 1'b1;
      step(2);
      reset_reset_n = 1'b0;
      nes_req = 1'b0;
      step();
      check_zero("rmid");
      reset_reset_n = 1'b1;
      step();
      check("rmid_norv", nes_rvalid, 0);
      step(2);
      nes_read(16'h0042, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/game_rom_bridge.md
Name: game_rom_bridge

Overview:
- Fabric-side responder for the SoC game-ROM conduit.
- The Nios software drives address, write data and read/write strobes. This block turns each strobe rising edge into a single-byte transaction on the game-ROM RAM port and returns read data on from_game_rom.
- It also arbitrates that RAM port with the NES core's cartridge read requests, with a starvation guard so ROM loading and debug reads progress while emulation runs.

Parameters:
- SYNC_STAGES, 2: flops in the write_rom/read_rom synchronizers (minimum 2).
- STARVE_MAX, 4: consecutive NES grants allowed while a SoC op is pending before the SoC is forced through.

Ports:
- clk_clk  in  1  system clock
- reset_reset_n  in  1  synchronous active-low reset
- rom_addr  in  16  SoC byte address; stable while a strobe is high
- to_game_rom  in  8  SoC write data
- write_rom  in  1  SoC write strobe (level; rising edge = one write)
- read_rom  in  1  SoC read strobe (level; rising edge = one read)
- from_game_rom  out  8  last SoC read data
- nes_req  in  1  NES read request; held until nes_rvalid
- nes_addr  in  16  NES read address
- nes_rdata  out  8  NES read data
- nes_rvalid  out  1  one-cycle NES data-valid pulse
- mem_addr  out  16  RAM address
- mem_wdata  out  8  RAM write data
- mem_we  out  1  RAM write enable
- mem_re  out  1  RAM read enable; mem_rdata is valid the cycle after mem_re
- mem_rdata  in  8  RAM read data
- wr_count_clr  in  1  clears wr_count
- wr_count  out  17  bytes written by the SoC since reset/clear
- soc_busy  out  1  SoC op pending or in flight
- soc_overrun  out  1  sticky: strobe edge arrived while the same-type op was still pending

Behaviour:
- Reset (clk_clk edge with reset_reset_n=0):
  - All outputs go to 0; state IDLE; pending flags and starvation counter cleared; synchronizers cleared.
  - A transaction in flight is abandoned: no nes_rvalid and no from_game_rom update.
- Strobe capture:
  - write_rom and read_rom each pass through SYNC_STAGES flops.
  - Rising edge = last stage high and previous value low.
  - On an edge, rom_addr (and to_game_rom for writes) is latched and wr_pend/rd_pend is set. The flag is visible the next cycle.
  - An edge while the same flag is already set overwrites the latched values and sets soc_overrun. soc_overrun clears only on reset.
- States: IDLE, ISSUE, CAPTURE.
- IDLE grant priority:
  1. SoC when starve_cnt == STARVE_MAX.
  2. Otherwise NES if nes_req.
  3. Otherwise SoC write pending.
  4. Otherwise SoC read pending.
  - If both SoC flags are set, write precedes read.
- Grant in cycle T:
  - At the T edge, the registered mem_addr plus mem_we/wdata or mem_re are asserted; they are visible in cycle T+1 (state ISSUE) for exactly one cycle.
  - Write: state returns to IDLE at T+2; wr_pend clears; wr_count increments, visible at T+2.
  - Read: state CAPTURE at T+2. At the T+2 edge, mem_rdata is registered into nes_rdata with nes_rvalid=1 for one cycle (NES), or into from_game_rom with rd_pend cleared (SoC). State is IDLE at T+3.
  - NES latency: nes_req sampled in IDLE at T gives nes_rvalid at T+3.
  - The requester drops nes_req in the nes_rvalid cycle. nes_req high in IDLE is always a new request.
- starve_cnt:
  - Increments on each NES grant while any SoC flag is set.
  - Clears on a SoC grant or when no SoC flag is set.
  - Saturates at STARVE_MAX.
- Memory strobes: mem_we and mem_re are never both high. Both are 0 in IDLE and CAPTURE.
- wr_count:
  - Wraps 0x1FFFF -> 0.
  - wr_count_clr forces 0 next cycle and has priority over a simultaneous increment.
- Held outputs: nes_rdata and from_game_rom hold their values between reads.
- soc_busy = wr_pend | rd_pend | (SoC op in ISSUE/CAPTURE).

Test Plan:
- Single write (SYNC_STAGES=2): rom_addr=0x8000, to_game_rom=0xA5, write_rom rises in cycle 0 -> mem_we=1, mem_addr=0x8000, mem_wdata=0xA5 in cycle 4 only; wr_count=1 in cycle 5; soc_busy falls in cycle 5.
- SoC read: RAM[0x8000]=0xA5, read_rom rises in cycle 0 -> mem_re in cycle 4; from_game_rom=0xA5 in cycle 6; held after read_rom falls.
- NES read: nes_req=1, nes_addr=0x1234 in IDLE at cycle T -> mem_re and addr 0x1234 at T+1; nes_rvalid=1 with RAM data at T+3 only.
- Starvation: NES re-requests back-to-back, SoC write pending -> SoC write issued after exactly 4 NES grants; NES is served again afterward.
- Simultaneous edges: write_rom and read_rom rise together, addr 0x0010, data 0x3C, RAM initially 0x00 -> write issued first; from_game_rom ends at 0x3C; soc_overrun stays 0.
- Reset mid-read: reset_reset_n=0 during CAPTURE -> next cycle all outputs 0, no nes_rvalid, state IDLE; a fresh nes_req then completes normally.
